// File: rtl/lu_new.sv
// Shared LU block-update constants, write-target mask bit positions and the
// state type of the CPU pipeline sequencer.
package lu_new;

  localparam int unsigned BSIZE        = 32;
  localparam int unsigned BSIZEBITS    = 5;
  localparam int unsigned LANES        = 8;
  localparam int unsigned LANESBITS    = 3;
  localparam int unsigned CACHE_AWIDTH = 2 * BSIZEBITS - LANESBITS;

  // Bit positions inside the {top, cur, left} write-target mask
  localparam int unsigned WR_LEFT = 0;
  localparam int unsigned WR_CUR  = 1;
  localparam int unsigned WR_TOP  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINAL,
    ST_DONE
  } cpu_ctrl_state_t;

endpackage

// File: rtl/lu_cpu_ctrl.sv
// Sequences one multiply-subtract block update through cpu_pipeline: one token
// per cycle over k, j, i (i in LANES steps), then waits for the pipe to drain.
module lu_cpu_ctrl
  import lu_new::*;
#(
  parameter int unsigned PIPE_DEPTH = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_page,
  input  logic [2:0] i_cmd_wr_sel,
  input  logic       i_hold,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_k_reset,
  output logic       o_k_inc,
  output logic       o_i_reset,
  output logic       o_i_inc,
  output logic       o_i_load_k1,
  output logic       o_j_reset,
  output logic       o_j_inc,
  output logic       o_j_load_k,
  output logic       o_j_load_k1,
  input  logic       i_k_done,
  input  logic       i_i_done,
  input  logic       i_j_done,
  output logic       o_valid,
  output logic       o_norm,
  output logic       o_recip,
  output logic       o_wr_top,
  output logic       o_wr_left,
  output logic       o_wr_cur,
  output logic       o_whichpage,
  input  logic       i_pipe_empty
);

  // A k sweep shorter than the pipeline must fully retire before the next starts
  localparam bit NEED_DRAIN = (BSIZE * BSIZE / LANES < PIPE_DEPTH);

  cpu_ctrl_state_t state_q, state_d;
  logic            page_q, page_d;
  logic [2:0]      wr_sel_q, wr_sel_d;

  logic sweep_end;
  assign sweep_end = !i_hold && i_i_done && i_j_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      page_q   <= 1'b0;
      wr_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      wr_sel_q <= wr_sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    wr_sel_d = wr_sel_q;
    unique case (state_q)
      ST_IDLE: if (i_cmd_valid) begin
        page_d   = i_cmd_page;
        wr_sel_d = i_cmd_wr_sel;
        state_d  = ST_INIT;
      end
      ST_INIT:  state_d = ST_ISSUE;
      ST_ISSUE: if (sweep_end) begin
        if (i_k_done)        state_d = ST_FINAL;
        else if (NEED_DRAIN) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (i_pipe_empty) state_d = ST_ISSUE;
      ST_FINAL: if (i_pipe_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic active;
  assign active = (state_q != ST_IDLE) && !reset;

  // Outputs are forced low while reset is held, even before the state register clears
  always_comb begin
    o_cmd_ready = 1'b0;
    o_done      = 1'b0;
    o_k_reset   = 1'b0;
    o_k_inc     = 1'b0;
    o_i_reset   = 1'b0;
    o_i_inc     = 1'b0;
    o_j_reset   = 1'b0;
    o_j_inc     = 1'b0;
    o_valid     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: o_cmd_ready = 1'b1;
        ST_INIT: begin
          o_k_reset = 1'b1;
          o_i_reset = 1'b1;
          o_j_reset = 1'b1;
        end
        ST_ISSUE: if (!i_hold) begin
          o_valid = 1'b1;
          if (!i_i_done) begin
            o_i_inc = 1'b1;
          end else begin
            o_i_reset = 1'b1;
            if (!i_j_done) begin
              o_j_inc = 1'b1;
            end else begin
              o_j_reset = 1'b1;
              o_k_inc   = !i_k_done;
            end
          end
        end
        ST_DONE: o_done = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy      = active;
  assign o_whichpage = active && page_q;
  assign o_wr_top    = active && wr_sel_q[WR_TOP];
  assign o_wr_cur    = active && wr_sel_q[WR_CUR];
  assign o_wr_left   = active && wr_sel_q[WR_LEFT];

  assign o_norm      = 1'b0;
  assign o_recip     = 1'b0;
  assign o_i_load_k1 = 1'b0;
  assign o_j_load_k  = 1'b0;
  assign o_j_load_k1 = 1'b0;

endmodule

// File: tb/tb_lu_cpu_ctrl.sv
// Scoreboard bench for lu_cpu_ctrl: a counter/occupancy model stands in for
// cpu_pipeline; dut0 uses the default depth, dut1 a depth that forces draining.
module tb_lu_cpu_ctrl;
  import lu_new::*;

  localparam int LAT    = 30;
  localparam int NTOK   = BSIZE * BSIZE * BSIZE / LANES;
  localparam int BASE_L = 1 + NTOK + 31 + 1;

  // Output vector bit positions
  localparam int B_RDY = 18, B_DONE = 17, B_BUSY = 16, B_KR = 15, B_KI = 14;
  localparam int B_IR = 13, B_II = 12, B_IK1 = 11, B_JR = 10, B_JI = 9;
  localparam int B_JK = 8, B_JK1 = 7, B_VAL = 6, B_NORM = 5, B_RCP = 4;
  localparam int B_TOP = 3, B_LEFT = 2, B_CUR = 1, B_PAGE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_page = 1'b0;
  logic [2:0]  cmd_wr = '0;
  logic        hold = 1'b0;
  logic        sel = 1'b0;
  logic [18:0] ov0, ov1, m;
  logic        k_done, i_done, j_done, pipe_empty;

  assign m = sel ? ov1 : ov0;

  lu_cpu_ctrl dut0 (
    .clk(clk), .reset(reset), .i_cmd_valid(cmd_valid && !sel), .o_cmd_ready(ov0[B_RDY]),
    .i_cmd_page(cmd_page), .i_cmd_wr_sel(cmd_wr), .i_hold(hold),
    .o_done(ov0[B_DONE]), .o_busy(ov0[B_BUSY]),
    .o_k_reset(ov0[B_KR]), .o_k_inc(ov0[B_KI]), .o_i_reset(ov0[B_IR]), .o_i_inc(ov0[B_II]),
    .o_i_load_k1(ov0[B_IK1]), .o_j_reset(ov0[B_JR]), .o_j_inc(ov0[B_JI]),
    .o_j_load_k(ov0[B_JK]), .o_j_load_k1(ov0[B_JK1]),
    .i_k_done(k_done), .i_i_done(i_done), .i_j_done(j_done),
    .o_valid(ov0[B_VAL]), .o_norm(ov0[B_NORM]), .o_recip(ov0[B_RCP]),
    .o_wr_top(ov0[B_TOP]), .o_wr_left(ov0[B_LEFT]), .o_wr_cur(ov0[B_CUR]),
    .o_whichpage(ov0[B_PAGE]), .i_pipe_empty(pipe_empty)
  );

  lu_cpu_ctrl #(.PIPE_DEPTH(200)) dut1 (
    .clk(clk), .reset(reset), .i_cmd_valid(cmd_valid && sel), .o_cmd_ready(ov1[B_RDY]),
    .i_cmd_page(cmd_page), .i_cmd_wr_sel(cmd_wr), .i_hold(hold),
    .o_done(ov1[B_DONE]), .o_busy(ov1[B_BUSY]),
    .o_k_reset(ov1[B_KR]), .o_k_inc(ov1[B_KI]), .o_i_reset(ov1[B_IR]), .o_i_inc(ov1[B_II]),
    .o_i_load_k1(ov1[B_IK1]), .o_j_reset(ov1[B_JR]), .o_j_inc(ov1[B_JI]),
    .o_j_load_k(ov1[B_JK]), .o_j_load_k1(ov1[B_JK1]),
    .i_k_done(k_done), .i_i_done(i_done), .i_j_done(j_done),
    .o_valid(ov1[B_VAL]), .o_norm(ov1[B_NORM]), .o_recip(ov1[B_RCP]),
    .o_wr_top(ov1[B_TOP]), .o_wr_left(ov1[B_LEFT]), .o_wr_cur(ov1[B_CUR]),
    .o_whichpage(ov1[B_PAGE]), .i_pipe_empty(pipe_empty)
  );

  // Downstream pipeline model: k/j/i counters and a registered empty flag
  int k_m, j_m, i_m, occ_cnt, cyc, acc_cyc, issued;
  assign k_done = (k_m == BSIZE - 1);
  assign j_done = (j_m == BSIZE - 1);
  assign i_done = (i_m == BSIZE - LANES);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m[B_RDY] && cmd_valid) acc_cyc <= cyc;
    if (m[B_VAL]) issued <= issued + 1;
    if (reset) begin
      k_m <= 0; j_m <= 0; i_m <= 0;
      occ_cnt <= LAT; pipe_empty <= 1'b1;
    end else begin
      if (m[B_KR]) k_m <= 0; else if (m[B_KI]) k_m <= k_m + 1;
      if (m[B_JR]) j_m <= 0; else if (m[B_JI]) j_m <= j_m + 1;
      if (m[B_IR]) i_m <= 0; else if (m[B_II]) i_m <= i_m + LANES;
      if (m[B_VAL]) begin
        occ_cnt <= 0; pipe_empty <= 1'b0;
      end else begin
        if (occ_cnt < LAT) occ_cnt <= occ_cnt + 1;
        pipe_empty <= (occ_cnt + 1 >= LAT);
      end
    end
  end

  initial begin cyc = 0; acc_cyc = 0; issued = 0; end

  // Scoreboard
  logic [18:0] tok_q[$];
  int          lat_q[$];
  int          checks = 0, errors = 0, done_cnt = 0;
  logic        prev_empty = 1'b1;

  function automatic logic [18:0] pack_tok(int k, int j, int i, logic pg, logic [2:0] wr);
    return {k[4:0], j[4:0], i[4:0], pg, wr};
  endfunction

  always @(negedge clk) begin
    if (m[B_VAL]) begin
      logic [18:0] act, exp_t;
      act = {k_m[4:0], j_m[4:0], i_m[4:0], m[B_PAGE], m[B_TOP], m[B_CUR], m[B_LEFT]};
      checks++;
      if (tok_q.size() == 0) begin
        errors++;
        $display("FAIL token: unexpected token got %h, none expected", act);
      end else begin
        exp_t = tok_q.pop_front();
        if (act !== exp_t) begin
          errors++;
          $display("FAIL token: got %h expected %h at cycle %0d", act, exp_t, cyc);
        end
      end
      if (sel && k_m > 0 && j_m == 0 && i_m == 0) begin
        checks++;
        if (prev_empty !== 1'b1) begin
          errors++;
          $display("FAIL drain: sweep %0d issued before empty, prev_empty %b expected 1", k_m, prev_empty);
        end
      end
    end
    if (hold && m[B_BUSY]) begin
      checks++;
      if (m[B_KR:B_JK1] !== '0 || m[B_VAL] !== 1'b0) begin
        errors++;
        $display("FAIL hold_ctrl: controls %b valid %b expected 0", m[B_KR:B_JK1], m[B_VAL]);
      end
    end
    if (m[B_DONE]) begin
      done_cnt++;
      checks++;
      if (lat_q.size() == 0) begin
        errors++;
        $display("FAIL done: unexpected o_done at cycle %0d", cyc);
      end else begin
        int el;
        el = lat_q.pop_front();
        if (cyc - acc_cyc != el) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", cyc - acc_cyc, el);
        end
      end
    end
    prev_empty <= pipe_empty;
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic check(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic issue_cmd(logic pg, logic [2:0] wr, int lat);
    for (int k = 0; k < BSIZE; k++)
      for (int j = 0; j < BSIZE; j++)
        for (int i = 0; i <= BSIZE - LANES; i += LANES)
          tok_q.push_back(pack_tok(k, j, i, pg, wr));
    lat_q.push_back(lat);
    cmd_page = pg; cmd_wr = wr; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_page = 1'b0; cmd_wr = '0;
  endtask

  task automatic wait_issued(int base, int n);
    int t = 0;
    while (issued - base < n && t < 20000) begin step(); t++; end
    if (t >= 20000) begin errors++; $display("FAIL wait_issued: timeout at %0d tokens", issued - base); end
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < 12000) begin step(); t++; end
    if (t >= 12000) begin errors++; $display("FAIL wait_done: timeout, o_done never seen"); end
    repeat (3) step();
  endtask

  initial begin
    int base;
    repeat (3) step();
    check("reset_outs0", int'(ov0), 0);
    check("reset_outs1", int'(ov1), 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", int'(ov0[B_RDY]), 1);
    check("busy_idle", int'(ov0[B_BUSY]), 0);

    // Basic command with a rejected request while busy
    issue_cmd(1'b1, 3'b010, BASE_L);
    repeat (50) step();
    check("ready_busy", int'(ov0[B_RDY]), 0);
    check("busy_mid", int'(ov0[B_BUSY]), 1);
    cmd_valid = 1'b1; cmd_page = 1'b0; cmd_wr = 3'b111;
    step();
    cmd_valid = 1'b0; cmd_wr = '0;
    wait_done();
    check("ready_after_done", int'(ov0[B_RDY]), 1);

    // Hold on the final token of sweep 0
    base = issued;
    issue_cmd(1'b0, 3'b101, BASE_L + 5);
    wait_issued(base, 127);
    hold = 1'b1;
    repeat (5) step();
    hold = 1'b0;
    wait_done();

    // Empty write mask still completes
    issue_cmd(1'b1, 3'b000, BASE_L);
    wait_done();

    // Reset mid-command
    base = issued;
    issue_cmd(1'b0, 3'b100, 0);
    wait_issued(base, 200);
    reset = 1'b1;
    step();
    check("reset_mid_outs", int'(ov0), 0);
    tok_q.delete(); lat_q.delete();
    reset = 1'b0;
    step();
    check("ready_after_mid_reset", int'(ov0[B_RDY]), 1);
    issue_cmd(1'b1, 3'b001, BASE_L);
    wait_done();

    // Draining configuration: 31 inter-sweep waits of 31 cycles
    sel = 1'b1;
    step();
    issue_cmd(1'b1, 3'b110, BASE_L + 31 * 31);
    wait_done();

    check("tok_q_empty", tok_q.size(), 0);
    check("lat_q_empty", lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
